// File: rtl/lectura_registros_pkg.sv
// Shared definitions for the dual read-port front end of the 8 x 16-bit register set.
package lectura_registros_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int NREGS     = 8;
  localparam int AW        = $clog2(NREGS);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } estado_t;

  // Reset fill bit for the response data register (all-zero word).
  localparam logic RSP_RST_BIT = 1'b0;

endpackage

// File: rtl/puerto_lectura.sv
// Single read port: 8:1 mux with same-cycle write forwarding, EMPTY/FULL response
// state machine and the response register.
module puerto_lectura
  import lectura_registros_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NREGS-1:0][WIDTH-1:0] q,
  input  logic [WIDTH-1:0]            d,
  input  logic [NREGS-1:0]            en,
  input  logic                        req_valid,
  input  logic [AW-1:0]               req_addr,
  output logic                        req_ready,
  output logic                        rsp_valid,
  output logic [WIDTH-1:0]            rsp_data,
  input  logic                        rsp_ready
);

  // A write landing on the addressed register this edge wins over its old contents.
  function automatic logic [WIDTH-1:0] sel_fwd(
    input logic [NREGS-1:0][WIDTH-1:0] regs,
    input logic [WIDTH-1:0]            wdata,
    input logic [NREGS-1:0]            wen,
    input logic [AW-1:0]               addr
  );
    return wen[addr] ? wdata : regs[addr];
  endfunction

  estado_t          state_p1;
  estado_t          state_nxt;
  logic             acc_p0;
  logic [WIDTH-1:0] data_p0;
  logic [WIDTH-1:0] data_p1;

  // Stage p0: request acceptance and read-data selection
  always_comb begin
    state_nxt = state_p1;
    req_ready = (state_p1 == EMPTY) || rsp_ready;
    acc_p0    = req_valid && req_ready;
    data_p0   = sel_fwd(q, d, en, req_addr);
    if (acc_p0) begin
      state_nxt = FULL;
    end else if (rsp_ready) begin
      state_nxt = EMPTY;
    end
  end

  // Stage p1: response state and snapshot register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_p1 <= EMPTY;
    end else begin
      state_p1 <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_p1 <= {WIDTH{RSP_RST_BIT}};
    end else if (acc_p0) begin
      data_p1 <= data_p0;
    end
  end

  assign rsp_valid = (state_p1 == FULL);
  assign rsp_data  = data_p1;

endmodule

// File: rtl/lectura_registros.sv
// Dual read-port front end: fans the register outputs and write bus out to two
// identical, independent read ports.
module lectura_registros
  import lectura_registros_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] q0,
  input  logic [WIDTH-1:0] q1,
  input  logic [WIDTH-1:0] q2,
  input  logic [WIDTH-1:0] q3,
  input  logic [WIDTH-1:0] q4,
  input  logic [WIDTH-1:0] q5,
  input  logic [WIDTH-1:0] q6,
  input  logic [WIDTH-1:0] q7,
  input  logic [WIDTH-1:0] d,
  input  logic             en0,
  input  logic             en1,
  input  logic             en2,
  input  logic             en3,
  input  logic             en4,
  input  logic             en5,
  input  logic             en6,
  input  logic             en7,
  input  logic             req_a_valid,
  input  logic [AW-1:0]    req_a_addr,
  output logic             req_a_ready,
  output logic             rsp_a_valid,
  output logic [WIDTH-1:0] rsp_a_data,
  input  logic             rsp_a_ready,
  input  logic             req_b_valid,
  input  logic [AW-1:0]    req_b_addr,
  output logic             req_b_ready,
  output logic             rsp_b_valid,
  output logic [WIDTH-1:0] rsp_b_data,
  input  logic             rsp_b_ready
);

  logic [NREGS-1:0][WIDTH-1:0] q_bus;
  logic [NREGS-1:0]            en_bus;

  assign q_bus  = {q7, q6, q5, q4, q3, q2, q1, q0};
  assign en_bus = {en7, en6, en5, en4, en3, en2, en1, en0};

  puerto_lectura #(.WIDTH(WIDTH)) u_puerto_a (
    .clk       (clk),
    .reset     (reset),
    .q         (q_bus),
    .d         (d),
    .en        (en_bus),
    .req_valid (req_a_valid),
    .req_addr  (req_a_addr),
    .req_ready (req_a_ready),
    .rsp_valid (rsp_a_valid),
    .rsp_data  (rsp_a_data),
    .rsp_ready (rsp_a_ready)
  );

  puerto_lectura #(.WIDTH(WIDTH)) u_puerto_b (
    .clk       (clk),
    .reset     (reset),
    .q         (q_bus),
    .d         (d),
    .en        (en_bus),
    .req_valid (req_b_valid),
    .req_addr  (req_b_addr),
    .req_ready (req_b_ready),
    .rsp_valid (rsp_b_valid),
    .rsp_data  (rsp_b_data),
    .rsp_ready (rsp_b_ready)
  );

endmodule

// File: tb/tb_lectura_registros.sv
// Directed bench for lectura_registros with per-port response scoreboards.
module tb_lectura_registros;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] q0, q1, q2, q3, q4, q5, q6, q7, d;
  logic        en0, en1, en2, en3, en4, en5, en6, en7;
  logic        req_a_valid, req_a_ready, rsp_a_valid, rsp_a_ready;
  logic [2:0]  req_a_addr;
  logic [15:0] rsp_a_data;
  logic        req_b_valid, req_b_ready, rsp_b_valid, rsp_b_ready;
  logic [2:0]  req_b_addr;
  logic [15:0] rsp_b_data;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_a[$];
  logic [15:0] exp_b[$];

  always #5 clk = ~clk;

  lectura_registros dut (
    .clk(clk), .reset(reset),
    .q0(q0), .q1(q1), .q2(q2), .q3(q3), .q4(q4), .q5(q5), .q6(q6), .q7(q7),
    .d(d),
    .en0(en0), .en1(en1), .en2(en2), .en3(en3), .en4(en4), .en5(en5), .en6(en6), .en7(en7),
    .req_a_valid(req_a_valid), .req_a_addr(req_a_addr), .req_a_ready(req_a_ready),
    .rsp_a_valid(rsp_a_valid), .rsp_a_data(rsp_a_data), .rsp_a_ready(rsp_a_ready),
    .req_b_valid(req_b_valid), .req_b_addr(req_b_addr), .req_b_ready(req_b_ready),
    .rsp_b_valid(rsp_b_valid), .rsp_b_data(rsp_b_data), .rsp_b_ready(rsp_b_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: a response handshake completes on the next rising edge.
  always @(negedge clk) begin
    if (reset && rsp_a_valid && rsp_a_ready) begin
      if (exp_a.size() == 0) chk("rsp_a_unexpected", {31'b0, rsp_a_valid}, 32'd0);
      else chk("rsp_a_data", {16'b0, rsp_a_data}, {16'b0, exp_a.pop_front()});
    end
    if (reset && rsp_b_valid && rsp_b_ready) begin
      if (exp_b.size() == 0) chk("rsp_b_unexpected", {31'b0, rsp_b_valid}, 32'd0);
      else chk("rsp_b_data", {16'b0, rsp_b_data}, {16'b0, exp_b.pop_front()});
    end
  end

  initial begin
    reset = 1'b0;
    {q0, q1, q2, q3, q4, q5, q6, q7, d} = '0;
    {en0, en1, en2, en3, en4, en5, en6, en7} = '0;
    req_a_valid = 1'b0; req_a_addr = '0; rsp_a_ready = 1'b0;
    req_b_valid = 1'b0; req_b_addr = '0; rsp_b_ready = 1'b0;
    repeat (2) tick();

    // Reset state
    chk("rst_rsp_a_valid", {31'b0, rsp_a_valid}, 32'd0);
    chk("rst_rsp_a_data", {16'b0, rsp_a_data}, 32'd0);
    chk("rst_rsp_b_valid", {31'b0, rsp_b_valid}, 32'd0);
    chk("rst_rsp_b_data", {16'b0, rsp_b_data}, 32'd0);
    chk("rst_req_a_ready", {31'b0, req_a_ready}, 32'd1);
    reset = 1'b1;
    tick();

    // Basic read
    q3 = 16'hBEEF;
    req_a_valid = 1'b1; req_a_addr = 3'd3; exp_a.push_back(16'hBEEF);
    tick();
    req_a_valid = 1'b0;
    chk("basic_valid", {31'b0, rsp_a_valid}, 32'd1);
    chk("basic_data", {16'b0, rsp_a_data}, 32'h0000BEEF);
    rsp_a_ready = 1'b1;
    tick();
    chk("basic_consumed", {31'b0, rsp_a_valid}, 32'd0);
    rsp_a_ready = 1'b0;

    // Same-cycle forwarding, then non-addressed enable ignored
    q5 = 16'h1111; d = 16'h2222; en5 = 1'b1;
    req_b_valid = 1'b1; req_b_addr = 3'd5; rsp_b_ready = 1'b1; exp_b.push_back(16'h2222);
    tick();
    chk("fwd_valid", {31'b0, rsp_b_valid}, 32'd1);
    chk("fwd_data", {16'b0, rsp_b_data}, 32'h00002222);
    en5 = 1'b0; en4 = 1'b1; exp_b.push_back(16'h1111);
    tick();
    en4 = 1'b0; req_b_valid = 1'b0;
    chk("nofwd_data", {16'b0, rsp_b_data}, 32'h00001111);
    tick();
    chk("fwd_drained", {31'b0, rsp_b_valid}, 32'd0);
    rsp_b_ready = 1'b0;

    // Back-to-back throughput
    q0 = 16'd0; q1 = 16'd1; q2 = 16'd2; q3 = 16'd3;
    rsp_a_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_a_valid = 1'b1; req_a_addr = 3'(i); exp_a.push_back(16'(i));
      chk("b2b_req_ready", {31'b0, req_a_ready}, 32'd1);
      tick();
      chk("b2b_valid", {31'b0, rsp_a_valid}, 32'd1);
      chk("b2b_data", {16'b0, rsp_a_data}, 32'(i));
    end
    req_a_valid = 1'b0;
    tick();
    chk("b2b_drained", {31'b0, rsp_a_valid}, 32'd0);

    // Backpressure: snapshot must not track a later write
    rsp_a_ready = 1'b0; q7 = 16'h00AA;
    req_a_valid = 1'b1; req_a_addr = 3'd7; exp_a.push_back(16'h00AA);
    tick();
    req_a_valid = 1'b0; q7 = 16'h00BB; d = 16'h00BB; en7 = 1'b1;
    tick();
    en7 = 1'b0;
    chk("hold_data", {16'b0, rsp_a_data}, 32'h000000AA);
    chk("hold_req_ready", {31'b0, req_a_ready}, 32'd0);
    tick();
    chk("hold_data2", {16'b0, rsp_a_data}, 32'h000000AA);
    chk("hold_valid", {31'b0, rsp_a_valid}, 32'd1);
    rsp_a_ready = 1'b1;
    #1;
    chk("hold_release_ready", {31'b0, req_a_ready}, 32'd1);
    tick();
    chk("hold_drained", {31'b0, rsp_a_valid}, 32'd0);

    // Simultaneous ports; B stalled while A streams
    q2 = 16'hC0DE; q6 = 16'hF00D; rsp_b_ready = 1'b0;
    req_a_valid = 1'b1; req_a_addr = 3'd2; exp_a.push_back(16'hC0DE);
    req_b_valid = 1'b1; req_b_addr = 3'd6; exp_b.push_back(16'hF00D);
    tick();
    req_b_valid = 1'b0;
    chk("dual_a_valid", {31'b0, rsp_a_valid}, 32'd1);
    chk("dual_b_valid", {31'b0, rsp_b_valid}, 32'd1);
    chk("dual_a_data", {16'b0, rsp_a_data}, 32'h0000C0DE);
    chk("dual_b_data", {16'b0, rsp_b_data}, 32'h0000F00D);
    req_a_addr = 3'd6; exp_a.push_back(16'hF00D);
    chk("dual_a_ready", {31'b0, req_a_ready}, 32'd1);
    tick();
    chk("dual_b_stalled", {31'b0, req_b_ready}, 32'd0);
    chk("dual_a_data2", {16'b0, rsp_a_data}, 32'h0000F00D);
    req_a_addr = 3'd2; exp_a.push_back(16'hC0DE);
    chk("dual_a_ready2", {31'b0, req_a_ready}, 32'd1);
    tick();
    req_a_valid = 1'b0;
    chk("dual_a_data3", {16'b0, rsp_a_data}, 32'h0000C0DE);
    tick();
    chk("dual_a_drained", {31'b0, rsp_a_valid}, 32'd0);
    chk("dual_b_held", {16'b0, rsp_b_data}, 32'h0000F00D);
    rsp_b_ready = 1'b1;
    tick();
    chk("dual_b_drained", {31'b0, rsp_b_valid}, 32'd0);
    rsp_b_ready = 1'b0;

    // Asynchronous reset while port A holds a stalled response
    rsp_a_ready = 1'b0; q1 = 16'h1234;
    req_a_valid = 1'b1; req_a_addr = 3'd1; exp_a.push_back(16'h1234);
    tick();
    req_a_valid = 1'b0;
    chk("mid_full", {31'b0, rsp_a_valid}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, rsp_a_valid}, 32'd0);
    chk("mid_rst_data", {16'b0, rsp_a_data}, 32'd0);
    exp_a.delete();
    tick();
    reset = 1'b1;
    chk("post_rst_ready", {31'b0, req_a_ready}, 32'd1);
    rsp_a_ready = 1'b1;
    tick();
    chk("post_rst_no_replay", {31'b0, rsp_a_valid}, 32'd0);
    tick();
    chk("post_rst_no_replay2", {31'b0, rsp_a_valid}, 32'd0);

    chk("sb_a_drained", 32'(exp_a.size()), 32'd0);
    chk("sb_b_drained", 32'(exp_b.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lectura_registros.md
Name: lectura_registros

Overview:
- Dual read-port front end for the 8 x 16-bit register set.
- Each port accepts a 3-bit register address on a valid/ready request channel and returns the selected register value on a valid/ready response channel.
- The block also snoops the register set's write bus (d, en0..en7). A read accepted in the same cycle as a write to that register returns the newly written value.
- It sits between the register set outputs and the datapath consumers (ALU operand fetch, debug read-out).

Parameters:
- WIDTH, 16, data width of each register and of the write bus.
- NREGS, 8, number of registers; fixed, sets address width AW = 3.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- q0..q7  in  WIDTH each  current register contents from the register set.
- d  in  WIDTH  write data bus driven to the register set.
- en0..en7  in  1 each  per-register write enables driven to the register set.
- req_a_valid  in  1  port A read request.
- req_a_addr  in  3  port A register index.
- req_a_ready  out  1  port A can accept a request.
- rsp_a_valid  out  1  port A response holds data.
- rsp_a_data  out  WIDTH  port A read data.
- rsp_a_ready  in  1  port A consumer takes the response.
- req_b_valid, req_b_addr, req_b_ready, rsp_b_valid, rsp_b_data, rsp_b_ready: same as port A, for port B.

Behaviour:
- Ports A and B are fully independent and identical. There is no arbitration; both may read the same register in the same cycle.
- Per-port state machine with two states:
  - EMPTY: rsp_valid = 0.
  - FULL: rsp_valid = 1.
- req_ready = (state == EMPTY) OR rsp_ready. This is combinational from rsp_ready, so back-to-back reads sustain 1 read/cycle.
- Accept: a request is accepted on the edge where req_valid && req_ready. The same edge:
  - loads rsp_data with en[addr] ? d : q[addr];
  - sets state FULL.
  - Latency is 1 cycle from acceptance to rsp_valid.
- Forwarding: en[addr] = 1 in the accept cycle means the register updates on this same edge, so the response carries d, the post-write value. Other en bits are ignored. If several en bits are set, only the addressed one matters.
- Consume: rsp_ready && FULL with no new accept -> EMPTY. Consume and accept on the same edge -> stay FULL with the new data.
- Hold: while FULL && !rsp_ready, rsp_data is a stable snapshot. It does not track later writes to that register. req_ready = 0 during hold.
- No request while EMPTY: outputs unchanged, rsp_data keeps its last value (don't-care to consumers).
- req_addr and req_valid are sampled only in the accept cycle; their values at other times are ignored.
- Reset (async, reset = 0):
  - state EMPTY, rsp_valid = 0, rsp_data = 0 on both ports.
  - Any pending response is dropped. req_ready = 1 immediately after reset release.
- Reset deassertion is synchronised externally; no internal synchroniser.
- No combinational path from q*/d/en* to any output. All outputs except req_ready are registered.

Decomposition:
- Shared package:
  - WIDTH default 16, NREGS = 8, AW = 3;
  - the port state enum {EMPTY, FULL};
  - reset value constant for rsp_data (zero).
- One sub-module, puerto_lectura (single read port), is instantiated twice. It contains:
  - the 8:1 read mux with forwarding select;
  - the EMPTY/FULL state machine;
  - the response register.
- The top level only fans q0..q7, d and en0..en7 out to both instances.

Test Plan:
- Reset then basic read: reset low, then high. q3 = 16'hBEEF, port A req addr 3 for one cycle -> rsp_a_valid = 1 next cycle with rsp_a_data = 16'hBEEF. rsp_a_ready = 1 -> rsp_a_valid = 0 the following cycle.
- Same-cycle forwarding: q5 = 16'h1111, d = 16'h2222, en5 = 1, port B reads addr 5 in the same cycle -> rsp_b_data = 16'h2222. Same stimulus with en4 = 1 instead -> 16'h1111.
- Back-to-back throughput: rsp_a_ready held 1, port A issues addr 0,1,2,3 on consecutive cycles (q0..q3 = 0,1,2,3) -> rsp_a_data = 0,1,2,3 on four consecutive cycles; req_a_ready never drops.
- Backpressure and snapshot: read addr 7 (q7 = 16'h00AA) with rsp_a_ready = 0, then write q7 := 16'h00BB -> rsp_a_data stays 16'h00AA and req_a_ready = 0 until rsp_a_ready = 1.
- Simultaneous ports: A reads addr 2, B reads addr 6, same cycle (q2 = 16'hC0DE, q6 = 16'hF00D) -> both valid next cycle with the correct data. B stalled with rsp_b_ready = 0 does not affect A's throughput.
- Reset mid-operation: port A FULL and stalled, assert reset low asynchronously mid-cycle -> rsp_a_valid = 0 and rsp_a_data = 0 immediately. After release, req_a_ready = 1 and the old response is not replayed.
